fir_mac_scheduler: RTL and testbench
====================================

FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
REQ-001 SHALL have parameter NUM_POS, default 7: positive-class taps per sample.
REQ-002 SHALL have parameter NUM_NEG, default 5: negative-class taps per sample (NUM_NEG <= NUM_POS).
REQ-003 SHALL have port iClk_12M, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port iRst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port iEnSample_600k, input, 1: one-cycle new-sample strobe.
REQ-006 SHALL have port iCoeffUpdReq, input, 1: level request for a coefficient-write window.
REQ-007 SHALL have ports iCsnRam / iWrnRam, input, 1 each: host RAM strobes, active-low.
REQ-008 SHALL have port iAddrRam, input, 4: host coefficient index; 0..6 pos, 7..11 neg.
REQ-009 SHALL have port iWrDtRam, input, 16 signed: host coefficient.
REQ-010 SHALL have port oCoeffUpdAck, output, 1: write window granted.
REQ-011 SHALL have ports oCsnRamPos, oWrnRamPos (1), oAddrRamPos (4), oWrDtRamPos (16): pos SRAM control.
REQ-012 SHALL have ports oCsnRamNeg, oWrnRamNeg (1), oAddrRamNeg (4), oWrDtRamNeg (16): neg SRAM control.
REQ-013 SHALL have ports oEnDelay, oAccClr, oEnSum, output, 1 each: delay-chain shift, accumulator clear, output-sum strobe.
REQ-014 SHALL have ports oEnMacPos / oEnMacNeg (1) and oMulSelPos / oMulSelNeg (3): multiply-accumulate enable and tap index.
REQ-015 SHALL have port oOverrun, output, 1: one-cycle pulse when a sample strobe cannot be serviced.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT, MAC, DONE, UPDATE.
REQ-017 IDLE: iEnSample_600k -> SHIFT; else iCoeffUpdReq -> UPDATE; sample wins when both assert in the same cycle.
REQ-018 SHIFT (1 cycle): oEnDelay=1, oAccClr=1; tap counter k cleared to 0; next state MAC.
REQ-019 MAC lasts NUM_POS+1 cycles, k=0..NUM_POS: for k<NUM_POS pos SRAM read (Csn=0, Wrn=1, addr=k); for k<NUM_NEG neg SRAM read at addr=k, else neg Csn=1.
REQ-020 SRAM read latency is 1 cycle: oEnMacPos=1 with oMulSelPos=k-1 for 1<=k<=NUM_POS; oEnMacNeg=1 with oMulSelNeg=k-1 for 1<=k<=NUM_NEG; otherwise enables 0 and selects 0.
REQ-021 DONE (1 cycle): oEnSum=1; next state IDLE. Strobe-to-oEnSum latency SHALL be NUM_POS+3 cycles (10 at defaults), well inside the 20-cycle sample period.
REQ-022 iEnSample_600k during SHIFT, MAC or DONE SHALL be ignored, with oOverrun=1 for that cycle.
REQ-023 iCoeffUpdReq during SHIFT/MAC/DONE SHALL be deferred until IDLE; no SRAM write occurs outside UPDATE.
REQ-024 UPDATE: oCoeffUpdAck=1; host strobes passed combinationally; iAddrRam 0..6 -> pos SRAM at iAddrRam; 7..11 -> neg SRAM at iAddrRam-7; other SRAM Csn=1.
REQ-025 UPDATE: iAddrRam 12..15 SHALL assert neither SRAM Csn (access dropped).
REQ-026 UPDATE: iEnSample_600k SHALL pulse oEnDelay and oOverrun for one cycle, with no MAC and no oEnSum (data history kept, output held).
REQ-027 UPDATE -> IDLE on the first cycle iCoeffUpdReq=0; oCoeffUpdAck falls the same cycle.
REQ-028 Tap counter SHALL be 3 bits and never exceed NUM_POS; no wrap within one sample.

Reset
REQ-029 iRst=1 at a clock edge SHALL force IDLE, k=0 and, from that edge, all Csn/Wrn=1, addresses/data=0, all enables/strobes/selects=0, oCoeffUpdAck=0, oOverrun=0.
REQ-030 Reset asserted mid-MAC or mid-UPDATE SHALL abort with no further oEnSum or SRAM access; operation resumes from IDLE on the first cycle after iRst=0.

Structure
REQ-031 Shared package fir_sched_pkg SHALL hold the state enum, NUM_POS/NUM_NEG defaults, NEG_ADDR_BASE=7, ADDR_LIMIT=12.
REQ-032 One sub-module fir_coeff_wr_mux SHALL implement the UPDATE-state host-to-SRAM address decode; FSM and counter remain in the top.

Verification
REQ-033 Strobe at cycle 0 from IDLE -> oEnDelay/oAccClr at 1; pos reads addr 0..6 at cycles 2..8; oEnMacPos cycles 3..9 sel 0..6; oEnMacNeg cycles 3..7 sel 0..4; oEnSum at cycle 10.
REQ-034 UPDATE with writes addr 3 data 0x1234 and addr 9 data 0xFFEC -> pos SRAM write at addr 3, neg SRAM write at addr 2 with data 0xFFEC; addr 13 write -> no Csn asserted.
REQ-035 Second strobe 5 cycles after the first -> oOverrun pulse, no second oEnDelay, single oEnSum at cycle 10.
REQ-036 Strobe and iCoeffUpdReq in the same IDLE cycle -> sample sequence first; oCoeffUpdAck rises the cycle after oEnSum.
REQ-037 Strobe during UPDATE -> oEnDelay=1 and oOverrun=1 same cycle, no oEnSum; iRst=1 at MAC cycle 4 -> all outputs at reset values from that edge, no oEnSum.

Source files
------------

// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR MAC scheduler.
// State encoding, tap counts, coefficient address map and SRAM bundle.
package fir_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_MAC,
    S_DONE,
    S_UPDATE
  } state_t;

  localparam int NUM_POS_DEF   = 7;
  localparam int NUM_NEG_DEF   = 5;
  localparam int NEG_ADDR_BASE = 7;
  localparam int ADDR_LIMIT    = 12;

  typedef struct packed {
    logic        csn;
    logic        wrn;
    logic [3:0]  addr;
    logic [15:0] data;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_IDLE = '{
    csn:  1'b1,
    wrn:  1'b1,
    addr: 4'd0,
    data: 16'd0
  };

endpackage

// File: rtl/fir_coeff_wr_mux.sv
// Host-to-SRAM coefficient write decode used while the update window is open.
// Ports: en (window open), host csn/wrn/addr/data in; pos and neg SRAM bundles out.
import fir_sched_pkg::*;

module fir_coeff_wr_mux (
  input  logic        en,
  input  logic        csn,
  input  logic        wrn,
  input  logic [3:0]  addr,
  input  logic [15:0] wr_dt,
  output logic        pos_csn,
  output logic        pos_wrn,
  output logic [3:0]  pos_addr,
  output logic [15:0] pos_data,
  output logic        neg_csn,
  output logic        neg_wrn,
  output logic [3:0]  neg_addr,
  output logic [15:0] neg_data
);

  localparam logic [3:0] NEG_BASE = 4'(NEG_ADDR_BASE);
  localparam logic [3:0] LIMIT    = 4'(ADDR_LIMIT);

  logic      pos_hit;
  logic      neg_hit;
  sram_ctl_t pos_c;
  sram_ctl_t neg_c;

  assign pos_hit = en && (addr < NEG_BASE);
  assign neg_hit = en && (addr >= NEG_BASE)
                      && (addr < LIMIT);

  always_comb begin
    pos_c = SRAM_IDLE;
    neg_c = SRAM_IDLE;
    unique case (1'b1)
      pos_hit: begin
        pos_c.csn  = csn;
        pos_c.wrn  = wrn;
        pos_c.addr = addr;
        pos_c.data = wr_dt;
      end
      neg_hit: begin
        neg_c.csn  = csn;
        neg_c.wrn  = wrn;
        neg_c.addr = addr - NEG_BASE;
        neg_c.data = wr_dt;
      end
      default: ;
    endcase
  end

  assign pos_csn  = pos_c.csn;
  assign pos_wrn  = pos_c.wrn;
  assign pos_addr = pos_c.addr;
  assign pos_data = pos_c.data;
  assign neg_csn  = neg_c.csn;
  assign neg_wrn  = neg_c.wrn;
  assign neg_addr = neg_c.addr;
  assign neg_data = neg_c.data;

endmodule

// File: rtl/fir_mac_scheduler.sv
// Per-sample FIR schedule: shift, tap-by-tap MAC over pos/neg SRAMs, sum.
// Also opens a host coefficient-write window between samples.
// Ports: iClk_12M/iRst, sample strobe, coeff update req/ack, host RAM bus,
// pos/neg SRAM control, datapath strobes, MAC enables/selects, oOverrun.
import fir_sched_pkg::*;

module fir_mac_scheduler #(
  parameter int NUM_POS = NUM_POS_DEF,
  parameter int NUM_NEG = NUM_NEG_DEF
) (
  input  logic               iClk_12M,
  input  logic               iRst,
  input  logic               iEnSample_600k,
  input  logic               iCoeffUpdReq,
  input  logic               iCsnRam,
  input  logic               iWrnRam,
  input  logic [3:0]         iAddrRam,
  input  logic signed [15:0] iWrDtRam,
  output logic               oCoeffUpdAck,
  output logic               oCsnRamPos,
  output logic               oWrnRamPos,
  output logic [3:0]         oAddrRamPos,
  output logic [15:0]        oWrDtRamPos,
  output logic               oCsnRamNeg,
  output logic               oWrnRamNeg,
  output logic [3:0]         oAddrRamNeg,
  output logic [15:0]        oWrDtRamNeg,
  output logic               oEnDelay,
  output logic               oAccClr,
  output logic               oEnSum,
  output logic               oEnMacPos,
  output logic               oEnMacNeg,
  output logic [2:0]         oMulSelPos,
  output logic [2:0]         oMulSelNeg,
  output logic               oOverrun
);

  localparam logic [2:0] K_POS = 3'(NUM_POS);
  localparam logic [2:0] K_NEG = 3'(NUM_NEG);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] k_q;
  logic [2:0] k_d;
  logic       upd_win;

  logic        wm_pos_csn;
  logic        wm_pos_wrn;
  logic [3:0]  wm_pos_addr;
  logic [15:0] wm_pos_data;
  logic        wm_neg_csn;
  logic        wm_neg_wrn;
  logic [3:0]  wm_neg_addr;
  logic [15:0] wm_neg_data;

  // Window closes combinationally as soon as the host drops its request.
  assign upd_win = (state_q == S_UPDATE) && iCoeffUpdReq;

  fir_coeff_wr_mux u_wr_mux (
    .en       (upd_win),
    .csn      (iCsnRam),
    .wrn      (iWrnRam),
    .addr     (iAddrRam),
    .wr_dt    (iWrDtRam),
    .pos_csn  (wm_pos_csn),
    .pos_wrn  (wm_pos_wrn),
    .pos_addr (wm_pos_addr),
    .pos_data (wm_pos_data),
    .neg_csn  (wm_neg_csn),
    .neg_wrn  (wm_neg_wrn),
    .neg_addr (wm_neg_addr),
    .neg_data (wm_neg_data)
  );

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (iEnSample_600k) begin
          state_d = S_SHIFT;
        end else if (iCoeffUpdReq) begin
          state_d = S_UPDATE;
        end
      end
      S_SHIFT: begin
        k_d     = 3'd0;
        state_d = S_MAC;
      end
      S_MAC: begin
        // Extra cycle at k == NUM_POS drains the read latency.
        if (k_q < K_POS) begin
          k_d = k_q + 3'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A request held during the sample opens the window right away.
        state_d = iCoeffUpdReq ? S_UPDATE : S_IDLE;
      end
      S_UPDATE: begin
        if (!iCoeffUpdReq) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oCoeffUpdAck = 1'b0;
    oCsnRamPos   = 1'b1;
    oWrnRamPos   = 1'b1;
    oAddrRamPos  = 4'd0;
    oWrDtRamPos  = 16'd0;
    oCsnRamNeg   = 1'b1;
    oWrnRamNeg   = 1'b1;
    oAddrRamNeg  = 4'd0;
    oWrDtRamNeg  = 16'd0;
    oEnDelay     = 1'b0;
    oAccClr      = 1'b0;
    oEnSum       = 1'b0;
    oEnMacPos    = 1'b0;
    oEnMacNeg    = 1'b0;
    oMulSelPos   = 3'd0;
    oMulSelNeg   = 3'd0;
    oOverrun     = 1'b0;
    unique case (state_q)
      S_SHIFT: begin
        oEnDelay = 1'b1;
        oAccClr  = 1'b1;
        oOverrun = iEnSample_600k;
      end
      S_MAC: begin
        oOverrun = iEnSample_600k;
        if (k_q < K_POS) begin
          oCsnRamPos  = 1'b0;
          oAddrRamPos = {1'b0, k_q};
        end
        if (k_q < K_NEG) begin
          oCsnRamNeg  = 1'b0;
          oAddrRamNeg = {1'b0, k_q};
        end
        // Data for tap k-1 arrives one cycle after its read.
        if (k_q != 3'd0) begin
          oEnMacPos  = 1'b1;
          oMulSelPos = k_q - 3'd1;
        end
        if ((k_q != 3'd0) && (k_q <= K_NEG)) begin
          oEnMacNeg  = 1'b1;
          oMulSelNeg = k_q - 3'd1;
        end
      end
      S_DONE: begin
        oEnSum   = 1'b1;
        oOverrun = iEnSample_600k;
      end
      S_UPDATE: begin
        oCoeffUpdAck = upd_win;
        oCsnRamPos   = wm_pos_csn;
        oWrnRamPos   = wm_pos_wrn;
        oAddrRamPos  = wm_pos_addr;
        oWrDtRamPos  = wm_pos_data;
        oCsnRamNeg   = wm_neg_csn;
        oWrnRamNeg   = wm_neg_wrn;
        oAddrRamNeg  = wm_neg_addr;
        oWrDtRamNeg  = wm_neg_data;
        // Keep the delay line in step; the sum output is held.
        oEnDelay     = iEnSample_600k;
        oOverrun     = iEnSample_600k;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: timeline model plus directed
// literal checks and randomized stimulus.
module tb_fir_mac_scheduler;

  localparam int NP = 7;
  localparam int NN = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic        req;
  logic        csn;
  logic        wrn;
  logic [3:0]  addr;
  logic signed [15:0] wdt;

  logic        ack;
  logic        pcsn, pwrn, ncsn, nwrn;
  logic [3:0]  paddr, naddr;
  logic [15:0] pdat, ndat;
  logic        endly, accclr, ensum, macp, macn, ovr;
  logic [2:0]  selp, seln;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_mac_scheduler #(.NUM_POS(NP), .NUM_NEG(NN)) dut (
    .iClk_12M       (clk),
    .iRst           (rst),
    .iEnSample_600k (strobe),
    .iCoeffUpdReq   (req),
    .iCsnRam        (csn),
    .iWrnRam        (wrn),
    .iAddrRam       (addr),
    .iWrDtRam       (wdt),
    .oCoeffUpdAck   (ack),
    .oCsnRamPos     (pcsn),
    .oWrnRamPos     (pwrn),
    .oAddrRamPos    (paddr),
    .oWrDtRamPos    (pdat),
    .oCsnRamNeg     (ncsn),
    .oWrnRamNeg     (nwrn),
    .oAddrRamNeg    (naddr),
    .oWrDtRamNeg    (ndat),
    .oEnDelay       (endly),
    .oAccClr        (accclr),
    .oEnSum         (ensum),
    .oEnMacPos      (macp),
    .oEnMacNeg      (macn),
    .oMulSelPos     (selp),
    .oMulSelNeg     (seln),
    .oOverrun       (ovr)
  );

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [56:0] dut_vec();
    return {ack, pcsn, pwrn, paddr, pdat, ncsn, nwrn, naddr, ndat,
            endly, accclr, ensum, macp, macn, selp, seln, ovr};
  endfunction

  // Model: ms = cycles since an accepted strobe (0 = no sample running),
  // mu = coefficient window open.
  int ms = 0;
  bit mu = 1'b0;
  bit mvalid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        logic e_ack, e_pc, e_pw, e_nc, e_nw;
        logic e_dly, e_clr, e_sum, e_mp, e_mn, e_ov;
        logic [3:0]  e_pa, e_na;
        logic [15:0] e_pd, e_nd;
        logic [2:0]  e_sp, e_sn;
        int r;
        int m;
        e_ack = 0; e_pc = 1; e_pw = 1; e_nc = 1; e_nw = 1;
        e_pa = 0; e_na = 0; e_pd = 0; e_nd = 0;
        e_dly = 0; e_clr = 0; e_sum = 0; e_mp = 0; e_mn = 0;
        e_sp = 0; e_sn = 0; e_ov = 0;
        if (ms > 0) begin
          e_ov = strobe;
          if (ms == 1) begin
            e_dly = 1; e_clr = 1;
          end
          r = ms - 2;
          m = ms - 3;
          if (r >= 0 && r < NP) begin
            e_pc = 0; e_pa = 4'(r);
          end
          if (r >= 0 && r < NN) begin
            e_nc = 0; e_na = 4'(r);
          end
          if (m >= 0 && m < NP) begin
            e_mp = 1; e_sp = 3'(m);
          end
          if (m >= 0 && m < NN) begin
            e_mn = 1; e_sn = 3'(m);
          end
          if (ms == NP + 3) e_sum = 1;
        end else if (mu) begin
          e_dly = strobe;
          e_ov = strobe;
          if (req) begin
            e_ack = 1;
            if (addr < 7) begin
              e_pc = csn; e_pw = wrn; e_pa = addr; e_pd = wdt;
            end else if (addr < 12) begin
              e_nc = csn; e_nw = wrn; e_na = addr - 4'd7; e_nd = wdt;
            end
          end
        end
        check("outputs", 64'(dut_vec()),
              64'({e_ack, e_pc, e_pw, e_pa, e_pd, e_nc, e_nw, e_na, e_nd,
                   e_dly, e_clr, e_sum, e_mp, e_mn, e_sp, e_sn, e_ov}));
      end
      @(posedge clk);
      if (rst) begin
        ms = 0; mu = 0; mvalid = 1;
      end else if (mvalid) begin
        if (ms > 0) begin
          if (ms < NP + 3) ms++;
          else begin
            ms = 0; mu = req;
          end
        end else if (mu) begin
          mu = req;
        end else if (strobe) begin
          ms = 1;
        end else if (req) begin
          mu = 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f_dly, f_sum, f_p, f_ack;
    int c_p, c_n, c_sum, c_dly, c_ov;
    logic [3:0] a8;
    logic [2:0] s5;
    logic got_ack;
    logic [7:0] idle_v;

    rst = 1; strobe = 0; req = 0; csn = 1; wrn = 1; addr = 0; wdt = 0;
    cyc(); cyc(); cyc();
    @(negedge clk);
    check("reset_state", 64'({pcsn, ncsn, pwrn, nwrn, ensum, ack, ovr}),
          64'(7'b1111000));
    cyc();
    rst = 0;
    cyc(); cyc();

    // Nominal sample timeline
    strobe = 1;
    f_dly = -1; f_sum = -1; f_p = -1; c_p = 0; c_n = 0; c_sum = 0;
    a8 = 0; s5 = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (endly && f_dly < 0) f_dly = n;
      if (ensum) begin
        c_sum++;
        if (f_sum < 0) f_sum = n;
      end
      if (macp) begin
        c_p++;
        if (f_p < 0) f_p = n;
      end
      if (macn) c_n++;
      if (n == 8) a8 = pcsn ? 4'hF : paddr;
      if (n == 5) s5 = selp;
      cyc();
      strobe = 0;
    end
    check("tl_delay_cycle", 64'(f_dly), 64'(1));
    check("tl_sum_cycle", 64'(f_sum), 64'(10));
    check("tl_sum_count", 64'(c_sum), 64'(1));
    check("tl_macp_first", 64'(f_p), 64'(3));
    check("tl_macp_count", 64'(c_p), 64'(7));
    check("tl_macn_count", 64'(c_n), 64'(5));
    check("tl_addr_c8", 64'(a8), 64'(6));
    check("tl_selp_c5", 64'(s5), 64'(2));

    // Coefficient window
    req = 1;
    got_ack = 0;
    for (int n = 0; n < 10 && !got_ack; n++) begin
      @(negedge clk);
      got_ack = ack;
      cyc();
    end
    check("ack_wait", 64'(got_ack), 64'(1));
    csn = 0; wrn = 0; addr = 4'd3; wdt = 16'h1234;
    @(negedge clk);
    check("wr_pos", 64'({pcsn, pwrn, paddr, pdat, ncsn}),
          64'({1'b0, 1'b0, 4'd3, 16'h1234, 1'b1}));
    cyc();
    addr = 4'd9; wdt = 16'hFFEC;
    @(negedge clk);
    check("wr_neg", 64'({ncsn, nwrn, naddr, ndat, pcsn}),
          64'({1'b0, 1'b0, 4'd2, 16'hFFEC, 1'b1}));
    cyc();
    addr = 4'd13;
    @(negedge clk);
    check("wr_drop", 64'({pcsn, ncsn}), 64'(2'b11));
    cyc();
    csn = 1; wrn = 1; addr = 0; strobe = 1;
    @(negedge clk);
    check("upd_strobe", 64'({endly, ovr, macp, accclr}), 64'(4'b1100));
    cyc();
    strobe = 0; req = 0;
    @(negedge clk);
    check("ack_fall", 64'(ack), 64'(0));
    c_sum = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (ensum) c_sum++;
      cyc();
    end
    check("upd_no_sum", 64'(c_sum), 64'(0));

    // Overrun on a second strobe 5 cycles in
    strobe = 1;
    c_ov = 0; c_dly = 0; c_sum = 0; f_sum = -1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (ovr) c_ov++;
      if (endly) c_dly++;
      if (ensum) begin
        c_sum++;
        if (f_sum < 0) f_sum = n;
      end
      cyc();
      strobe = (n + 1 == 5);
    end
    check("ov_count", 64'(c_ov), 64'(1));
    check("ov_delay_count", 64'(c_dly), 64'(1));
    check("ov_sum_count", 64'(c_sum), 64'(1));
    check("ov_sum_cycle", 64'(f_sum), 64'(10));

    // Strobe and request together: sample first
    strobe = 1; req = 1;
    f_sum = -1; f_ack = -1;
    for (int n = 0; n < 17; n++) begin
      @(negedge clk);
      if (ensum && f_sum < 0) f_sum = n;
      if (ack && f_ack < 0) f_ack = n;
      cyc();
      strobe = 0;
    end
    check("both_sum_cycle", 64'(f_sum), 64'(10));
    check("both_ack_cycle", 64'(f_ack), 64'(11));
    req = 0;
    cyc(); cyc();

    // Reset at MAC cycle k=4
    strobe = 1;
    c_sum = 0; idle_v = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (ensum) c_sum++;
      if (n == 7)
        idle_v = {pcsn, ncsn, pwrn, nwrn, macp, macn, accclr, ovr};
      cyc();
      strobe = 0;
      rst = (n + 1 == 6);
    end
    check("rst_no_sum", 64'(c_sum), 64'(0));
    check("rst_idle_outs", 64'(idle_v), 64'(8'b11110000));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      strobe = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 30) == 0) req = ~req;
      csn  = 1'($urandom);
      wrn  = 1'($urandom);
      addr = 4'($urandom_range(0, 15));
      wdt  = 16'($urandom);
      rst  = ($urandom_range(0, 400) == 0);
      cyc();
    end
    strobe = 0; req = 0; rst = 0;
    cyc(); cyc();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
